input_data_buffer: RTL
======================

INPUT_DATA_BUFFER -- requirements
Module: input_data_buffer

Interface
REQ-001 The block SHALL expose parameter DataInputWidth, default 8, the operand word width in bits.
REQ-002 The block SHALL expose parameter Depth, default 4, the FIFO entry count; legal values are powers of two, 2 to 64.
REQ-003 The block SHALL expose parameter Stages, default 5, matching the downstream MAC/output pipeline depth.
REQ-004 The block SHALL have port clk, input, 1, the single clock, with all state updated on its rising edge.
REQ-005 The block SHALL have port aclr, input, 1, the reset, which is asynchronous and active-high.
REQ-006 The block SHALL have port sclr, input, 1, a synchronous active-high flush.
REQ-007 The block SHALL have port InValid, input, 1, upstream word valid.
REQ-008 The block SHALL have port InReady, output, 1, buffer can accept a word.
REQ-009 The block SHALL have port DataIn, input, DataInputWidth, upstream word.
REQ-010 The block SHALL have port IssueEn, input, 1, downstream pipeline accepts the head word this cycle.
REQ-011 The block SHALL have port IssueValid, output, 1, head word available.
REQ-012 The block SHALL have port IssueData, output, DataInputWidth, head word.
REQ-013 The block SHALL have port RetireValid, output, 1, the issued-word tag delayed to line up with the output pipeline result.
REQ-014 The block SHALL have port Count, output, log2(Depth)+1, current occupancy.
REQ-015 The block SHALL have ports Full and Empty, output, 1 each, occupancy flags.

Function
REQ-016 Push: the buffer SHALL write DataIn at the write pointer and increment it when InValid && InReady.
REQ-017 InReady SHALL equal !Full combinationally, so a push is impossible when full even with a same-cycle pop (no pass-through).
REQ-018 Show-ahead: IssueValid SHALL equal !Empty, and IssueData SHALL equal the entry at the read pointer, with no register stage.
REQ-019 Pop: the buffer SHALL advance the read pointer when IssueValid && IssueEn; IssueEn while empty SHALL have no effect.
REQ-020 Pointers SHALL be log2(Depth)+1 bits and wrap modulo 2*Depth. Full SHALL be asserted when the MSBs differ and the low bits are equal. Empty SHALL be asserted when the pointers are equal.
REQ-021 Count SHALL be the write pointer minus the read pointer, and SHALL be unchanged on a simultaneous push and pop.
REQ-022 A tag shift chain of Stages+1 bits SHALL load the pop indication into bit 0 each cycle and shift it one bit per cycle.
REQ-023 RetireValid SHALL equal the top bit of the tag chain, giving assertion exactly Stages+1 cycles after the pop cycle; this matches the downstream data latency.
REQ-024 A 1-cycle pop pulse SHALL give a 1-cycle RetireValid pulse, and back-to-back pops SHALL give back-to-back RetireValid.
REQ-025 sclr SHALL take priority over push and pop. On the next edge it SHALL zero both pointers and the tag chain; FIFO data contents need not be cleared.
REQ-026 During the sclr cycle, any push or pop handshake SHALL be discarded.

Reset
REQ-027 While aclr is high, the pointers and tag chain SHALL be cleared immediately, independent of clk.
REQ-028 Output values during and after reset SHALL be: InReady=1, IssueValid=0, RetireValid=0, Count=0, Full=0, Empty=1.
REQ-029 An aclr mid-operation SHALL discard all buffered and in-flight words, and no RetireValid SHALL appear for them.
REQ-030 Deassertion of aclr SHALL be synchronised externally; the block SHALL need no internal reset synchroniser.

Structure
REQ-031 A shared package SHALL hold the default width, depth and Stages constants, shared with the output pipeline so latencies cannot diverge.
REQ-032 The Stages+1 tag chain SHALL be a sub-module named valid_tag_pipeline, with parameter Stages and ports clk, aclr, sclr, TagIn, TagOut.
REQ-033 FIFO storage SHALL be a register array, not inferred RAM.

Verification
REQ-034 Bench: reset, then push 0x11,0x22,0x33 with IssueEn=0 -> Count=3, IssueData=0x11, InReady=1.
REQ-035 Bench: push 4 words at Depth=4 -> Full=1, InReady=0; InValid held with 0x55 -> 0x55 not stored; one pop -> InReady=1 next cycle.
REQ-036 Bench: single pop at cycle 10, Stages=5 -> RetireValid high only at cycle 16.
REQ-037 Bench: continuous push and pop for 20 cycles, Count=2 steady -> 0x00..0x13 issued in order and pointer wrap observed.
REQ-038 Bench: 3 words buffered with 2 tags in flight, then sclr pulse -> next cycle Empty=1, Count=0; no RetireValid follows.
REQ-039 Bench: aclr asserted mid-cycle with Full=1 -> outputs reach reset values before the next clk edge.

Source files
------------

// File: rtl/input_data_buffer_pkg.sv
// Constants shared by the input buffer and the downstream MAC/output pipeline.
// Keeping them in one place stops the retire latency drifting from the data latency.
package input_data_buffer_pkg;

    localparam int DefaultDataInputWidth = 8;
    localparam int DefaultDepth          = 4;
    localparam int DefaultStages         = 5;

    // Pointer width carries one extra wrap bit so that full and empty are distinguishable.
    function automatic int ptrWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/input_data_buffer_valid_tag_pipeline.sv
// Stages+1 bit shift chain that delays the pop indication so that it lines up
// with the result leaving the downstream pipeline.
module valid_tag_pipeline #(
    parameter int Stages = 5
) (
    input  logic clk,
    input  logic aclr,
    input  logic sclr,
    input  logic TagIn,
    output logic TagOut
);

    logic [Stages:0] tagReg;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            tagReg <= '0;
        end else if (sclr) begin
            tagReg <= '0;
        end else begin
            tagReg <= {tagReg[Stages-1:0], TagIn};
        end
    end

    assign TagOut = tagReg[Stages];

endmodule

// File: rtl/input_data_buffer.sv
// Show-ahead operand FIFO in front of the MAC pipeline, with a retire tag that
// emerges when the issued word's result leaves the output pipeline.
module input_data_buffer
    import input_data_buffer_pkg::*;
#(
    parameter int DataInputWidth = DefaultDataInputWidth,
    parameter int Depth          = DefaultDepth,
    parameter int Stages         = DefaultStages
) (
    input  logic                            clk,
    input  logic                            aclr,
    input  logic                            sclr,
    input  logic                            InValid,
    output logic                            InReady,
    input  logic [DataInputWidth-1:0]       DataIn,
    input  logic                            IssueEn,
    output logic                            IssueValid,
    output logic [DataInputWidth-1:0]       IssueData,
    output logic                            RetireValid,
    output logic [ptrWidth(Depth)-1:0]      Count,
    output logic                            Full,
    output logic                            Empty
);

    localparam int AddrW = $clog2(Depth);
    localparam int PtrW  = ptrWidth(Depth);

    logic [PtrW-1:0]           wrPtrReg;
    logic [PtrW-1:0]           rdPtrReg;
    logic [DataInputWidth-1:0] memReg [Depth];
    logic                      push;
    logic                      pop;

    assign Full  = (wrPtrReg[AddrW] != rdPtrReg[AddrW]) &&
                   (wrPtrReg[AddrW-1:0] == rdPtrReg[AddrW-1:0]);
    assign Empty = (wrPtrReg == rdPtrReg);
    assign Count = wrPtrReg - rdPtrReg;

    // No pass-through: a full buffer refuses a word even if the head leaves this cycle.
    assign InReady    = !Full;
    assign IssueValid = !Empty;
    assign IssueData  = memReg[rdPtrReg[AddrW-1:0]];

    assign push = InValid && InReady;
    assign pop  = IssueValid && IssueEn;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
        end else if (sclr) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
        end else begin
            if (push) begin
                wrPtrReg <= wrPtrReg + 1'b1;
            end
            if (pop) begin
                rdPtrReg <= rdPtrReg + 1'b1;
            end
        end
    end

    // Storage is plain registers; contents are never reset, only the pointers are.
    for (genvar gi = 0; gi < Depth; gi++) begin : gEntry
        always_ff @(posedge clk) begin
            if (push && !sclr && (wrPtrReg[AddrW-1:0] == AddrW'(gi))) begin
                memReg[gi] <= DataIn;
            end
        end
    end

    valid_tag_pipeline #(
        .Stages (Stages)
    ) uTagPipe (
        .clk    (clk),
        .aclr   (aclr),
        .sclr   (sclr),
        .TagIn  (pop),
        .TagOut (RetireValid)
    );

endmodule
